shift_reg_usr: RTL and testbench

SHIFT_REG_USR -- requirements
Module: shift_reg_usr

---
 rtl/shift_reg_usr.sv | 130 +++++++++++++
 tb/tb_shift_reg_usr.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_usr.sv
// shift_reg_usr
//
// Command-driven universal shift register. In IDLE a start request latches
// the command (mode, count, data). LOAD completes at the accept edge. A
// shift, shift-right or rotate command runs for 'count' single-bit steps,
// one per clock, and then pulses done for one cycle.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      command request, honoured only in IDLE
//   mode   in   2      00 LOAD, 01 SHL, 10 SHR, 11 ROT (rotate left)
//   count  in   CW     number of single-bit steps (ignored for LOAD)
//   d      in   WIDTH  parallel load data
//   sin    in   1      serial fill bit, sampled on every step edge
//   q      out  WIDTH  register contents
//   qb     out  WIDTH  bitwise complement of q
//   sout   out  1      bit that the next step shifts out
//   busy   out  1      high while a multi-step command is in RUN
//   done   out  1      one-cycle completion pulse
module shift_reg_usr #(
   parameter int unsigned       WIDTH   = 8,
   parameter int unsigned       CW      = 4,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CW-1:0]    count,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] M_LOAD = 2'b00;
   localparam logic [1:0] M_SHL  = 2'b01;
   localparam logic [1:0] M_SHR  = 2'b10;
   localparam logic [1:0] M_ROT  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q,  mode_d;
   logic [CW-1:0]    rem_q,   rem_d;
   logic [WIDTH-1:0] data_q,  data_d;

   // One single-bit step of the latched command.
   function automatic logic [WIDTH-1:0] step(input logic [1:0]       m,
                                             input logic [WIDTH-1:0] v,
                                             input logic             s);
      logic [WIDTH-1:0] r;
      r = v;
      case (m)
         M_SHL:   r = {v[WIDTH-2:0], s};
         M_SHR:   r = {s, v[WIDTH-1:1]};
         M_ROT:   r = {v[WIDTH-2:0], v[WIDTH-1]};
         default: r = v;
      endcase
      return r;
   endfunction

   // Command acceptance and step sequencing
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d = mode;
               if (mode == M_LOAD) begin
                  data_d  = d;
                  state_d = S_DONE;
               end else if (count == '0) begin
                  state_d = S_DONE;
               end else begin
                  rem_d   = count;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            data_d = step(mode_q, data_q, sin);
            rem_d  = rem_q - CW'(1);
            // The edge that performs the final step leaves RUN.
            if (rem_q == CW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= M_LOAD;
         rem_q   <= '0;
         data_q  <= RST_VAL;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
      end
   end

   // Outputs decoded from registered state only
   assign q    = data_q;
   assign qb   = ~data_q;
   assign sout = (mode_q == M_SHR) ? data_q[0] : data_q[WIDTH-1];
   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_reg_usr.sv
module tb_shift_reg_usr;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic [3:0] count;
   logic [7:0] d;
   logic       sin;
   logic [7:0] q;
   logic [7:0] qb;
   logic       sout;
   logic       busy;
   logic       done;

   int total;
   int bad;

   logic [7:0] rot_exp [8];

   shift_reg_usr #(.WIDTH(8), .CW(4), .RST_VAL(8'h00)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mode  (mode),
      .count (count),
      .d     (d),
      .sin   (sin),
      .q     (q),
      .qb    (qb),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rot_exp[0] = 8'h03; rot_exp[1] = 8'h06; rot_exp[2] = 8'h0C; rot_exp[3] = 8'h18;
      rot_exp[4] = 8'h30; rot_exp[5] = 8'h60; rot_exp[6] = 8'hC0; rot_exp[7] = 8'h81;

      rst = 1'b0; start = 1'b0; mode = 2'b00; count = 4'd0; d = 8'h00; sin = 1'b0;

      // Asynchronous reset mid-cycle, checked before any clock edge
      #3 rst = 1'b1;
      #1;
      check("rst_q",    32'(q),    32'h00);
      check("rst_qb",   32'(qb),   32'hFF);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      tick();
      rst = 1'b0;

      // LOAD A5
      start = 1'b1; mode = 2'b00; d = 8'hA5;
      tick();
      start = 1'b0;
      check("load_q",    32'(q),    32'hA5);
      check("load_qb",   32'(qb),   32'h5A);
      check("load_done", 32'(done), 32'h1);
      check("load_busy", 32'(busy), 32'h0);
      tick();
      check("load_done_low", 32'(done), 32'h0);
      check("load_busy_low", 32'(busy), 32'h0);
      check("load_hold",     32'(q),    32'hA5);

      // SHL count=3 sin=1
      start = 1'b1; mode = 2'b01; count = 4'd3; sin = 1'b1;
      tick();
      start = 1'b0; mode = 2'b10; count = 4'd9; d = 8'h00;  // must not disturb the run
      check("shl_busy0", 32'(busy), 32'h1);
      check("shl_sout0", 32'(sout), 32'h1);
      check("shl_q0",    32'(q),    32'hA5);
      tick();
      check("shl_q1",    32'(q),    32'h4B);
      check("shl_busy1", 32'(busy), 32'h1);
      tick();
      check("shl_q2",    32'(q),    32'h97);
      check("shl_busy2", 32'(busy), 32'h1);
      tick();
      check("shl_q3",    32'(q),    32'h2F);
      check("shl_busy3", 32'(busy), 32'h0);
      check("shl_done",  32'(done), 32'h1);
      tick();
      check("shl_idle_done", 32'(done), 32'h0);
      check("shl_idle_q",    32'(q),    32'h2F);

      // SHR count=2 sin=0
      start = 1'b1; mode = 2'b10; count = 4'd2; sin = 1'b0;
      tick();
      start = 1'b0;
      check("shr_busy0", 32'(busy), 32'h1);
      check("shr_sout0", 32'(sout), 32'h1);
      tick();
      check("shr_q1",    32'(q),    32'h17);
      check("shr_sout1", 32'(sout), 32'h1);
      check("shr_busy1", 32'(busy), 32'h1);
      tick();
      check("shr_q2",    32'(q),    32'h0B);
      check("shr_done",  32'(done), 32'h1);
      check("shr_busy2", 32'(busy), 32'h0);
      tick();

      // LOAD 81 then ROT count=8 with an ignored start during RUN
      start = 1'b1; mode = 2'b00; d = 8'h81;
      tick();
      start = 1'b0;
      check("load81_q", 32'(q), 32'h81);
      tick();
      start = 1'b1; mode = 2'b11; count = 4'd8;
      tick();
      start = 1'b0;
      check("rot_busy0", 32'(busy), 32'h1);
      check("rot_sout0", 32'(sout), 32'h1);
      for (int i = 0; i < 8; i++) begin
         if (i == 1) begin
            start = 1'b1; mode = 2'b00; d = 8'hFF;
         end
         if (i == 3) begin
            start = 1'b0;
         end
         tick();
         check($sformatf("rot_q%0d", i),    32'(q),    32'(rot_exp[i]));
         check($sformatf("rot_busy%0d", i), 32'(busy), (i < 7) ? 32'h1 : 32'h0);
         check($sformatf("rot_done%0d", i), 32'(done), (i == 7) ? 32'h1 : 32'h0);
      end
      tick();
      check("rot_idle_q",    32'(q),    32'h81);
      check("rot_idle_done", 32'(done), 32'h0);

      // count=0 command completes immediately
      start = 1'b1; mode = 2'b01; count = 4'd0; sin = 1'b1;
      tick();
      start = 1'b0;
      check("cnt0_done", 32'(done), 32'h1);
      check("cnt0_busy", 32'(busy), 32'h0);
      check("cnt0_q",    32'(q),    32'h81);
      tick();
      check("cnt0_idle", 32'(done), 32'h0);
      check("cnt0_hold", 32'(q),    32'h81);

      // Reset in the middle of SHL count=10
      start = 1'b1; mode = 2'b01; count = 4'd10; sin = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("abort_q4",    32'(q),    32'h10);
      check("abort_busy4", 32'(busy), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("abort_q",    32'(q),    32'h00);
      check("abort_qb",   32'(qb),   32'hFF);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("abort_nodone%0d", i), 32'(done), 32'h0);
      end

      // Start accepted on the first edge after reset release
      #2 rst = 1'b1;
      tick();
      rst = 1'b0; start = 1'b1; mode = 2'b00; d = 8'h3C;
      tick();
      start = 1'b0;
      check("post_rst_load_q",    32'(q),    32'h3C);
      check("post_rst_load_done", 32'(done), 32'h1);
      tick();
      check("post_rst_idle", 32'(done), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
